// File: rtl/or_bus_initiator_pkg.sv
// Register map, FSM state encodings and default poll limit for the
// register-bus initiator that drives an external OR unit.
package or_bus_initiator_pkg;

    localparam logic [2:0] REG_A_NOT_FULL  = 3'd0;
    localparam logic [2:0] REG_B_NOT_FULL  = 3'd1;
    localparam logic [2:0] REG_Y_NOT_EMPTY = 3'd2;
    localparam logic [2:0] REG_Y_DATA      = 3'd3;
    localparam logic [2:0] REG_A_DATA      = 3'd4;
    localparam logic [2:0] REG_B_DATA      = 3'd5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POLL_A = 3'd1;
    localparam logic [2:0] ST_WR_A   = 3'd2;
    localparam logic [2:0] ST_POLL_B = 3'd3;
    localparam logic [2:0] ST_WR_B   = 3'd4;
    localparam logic [2:0] ST_POLL_Y = 3'd5;
    localparam logic [2:0] ST_RD_Y   = 3'd6;
    localparam logic [2:0] ST_RESP   = 3'd7;

    localparam int POLL_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/or_bus_initiator.sv
// Command -> register-bus sequencer: polls FIFO status, writes A/B, reads Y back.
// Latency 7 cycles from command accept to res_valid when the bus never stalls.
module or_bus_initiator
    import or_bus_initiator_pkg::*;
#(
    parameter int POLL_LIMIT = POLL_LIMIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_a,
    input  logic        cmd_b,
    input  logic        cmd_valid,
    output logic        cmd_rdy,
    output logic        res_y,
    output logic        res_valid,
    input  logic        res_rdy,
    output logic [2:0]  write_address,
    output logic        write_data,
    output logic        write_en,
    input  logic        write_rdy,
    output logic [2:0]  read_address,
    output logic        read_en,
    input  logic        read_data,
    input  logic        read_rdy,
    output logic        timeout_err,
    output logic [15:0] txn_count
);

    localparam logic [8:0] LP_LIMIT = 9'(POLL_LIMIT);

    logic [2:0]  r_state;
    logic        r_a;
    logic        r_b;
    logic        r_res_y;
    logic [7:0]  r_poll_cnt;
    logic        r_timeout;
    logic [15:0] r_txn;

    logic [2:0]  w_state_nxt;
    logic        w_rd_done;
    logic        w_wr_done;
    logic [8:0]  w_poll_next;
    logic        w_poll_expire;

    assign w_rd_done     = read_en && read_rdy;
    assign w_wr_done     = write_en && write_rdy;
    assign w_poll_next   = {1'b0, r_poll_cnt} + 9'd1;
    assign w_poll_expire = (w_poll_next >= LP_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cmd_valid) w_state_nxt = ST_POLL_A;
            ST_POLL_A: if (w_rd_done)
                           w_state_nxt = read_data ? ST_WR_A : (w_poll_expire ? ST_IDLE : ST_POLL_A);
            ST_WR_A:   if (w_wr_done) w_state_nxt = ST_POLL_B;
            ST_POLL_B: if (w_rd_done)
                           w_state_nxt = read_data ? ST_WR_B : (w_poll_expire ? ST_IDLE : ST_POLL_B);
            ST_WR_B:   if (w_wr_done) w_state_nxt = ST_POLL_Y;
            ST_POLL_Y: if (w_rd_done)
                           w_state_nxt = read_data ? ST_RD_Y : (w_poll_expire ? ST_IDLE : ST_POLL_Y);
            ST_RD_Y:   if (w_rd_done) w_state_nxt = ST_RESP;
            ST_RESP:   if (res_rdy) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_res_y    <= 1'b0;
            r_poll_cnt <= 8'd0;
            r_timeout  <= 1'b0;
            r_txn      <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_poll_cnt <= 8'd0;
                    if (cmd_valid) begin
                        r_a <= cmd_a;
                        r_b <= cmd_b;
                    end
                end
                // Only polls that complete with "not ready" consume budget.
                ST_POLL_A, ST_POLL_B, ST_POLL_Y: begin
                    if (w_rd_done && !read_data) begin
                        if (w_poll_expire) r_timeout  <= 1'b1;
                        else               r_poll_cnt <= r_poll_cnt + 8'd1;
                    end
                end
                ST_RD_Y: begin
                    r_poll_cnt <= 8'd0;
                    if (w_rd_done) r_res_y <= read_data;
                end
                ST_RESP: begin
                    r_poll_cnt <= 8'd0;
                    if (res_rdy) r_txn <= r_txn + 16'd1;
                end
                default: r_poll_cnt <= 8'd0;
            endcase
        end
    end

    // Bus strobes are pure state decodes, so address/data hold until the handshake.
    always_comb begin
        read_en       = 1'b0;
        read_address  = 3'd0;
        write_en      = 1'b0;
        write_address = 3'd0;
        write_data    = 1'b0;
        case (r_state)
            ST_POLL_A: begin read_en = 1'b1; read_address = REG_A_NOT_FULL;  end
            ST_POLL_B: begin read_en = 1'b1; read_address = REG_B_NOT_FULL;  end
            ST_POLL_Y: begin read_en = 1'b1; read_address = REG_Y_NOT_EMPTY; end
            ST_RD_Y:   begin read_en = 1'b1; read_address = REG_Y_DATA;      end
            ST_WR_A: begin
                write_en      = 1'b1;
                write_address = REG_A_DATA;
                write_data    = r_a;
            end
            ST_WR_B: begin
                write_en      = 1'b1;
                write_address = REG_B_DATA;
                write_data    = r_b;
            end
            default: ;
        endcase
    end

    assign cmd_rdy     = (r_state == ST_IDLE) && !RST;
    assign res_valid   = (r_state == ST_RESP);
    assign res_y       = r_res_y;
    assign timeout_err = r_timeout;
    assign txn_count   = r_txn;

endmodule

// File: tb/tb_or_bus_initiator.sv
// Bench: OR-unit register model on the bus, result scoreboard, a second
// instance with a small poll limit for the timeout path.
module tb_or_bus_initiator;
    import or_bus_initiator_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST = 1'b1;
    logic cmd_a = 1'b0, cmd_b = 1'b0, cmd_valid = 1'b0, res_rdy = 1'b0;
    logic write_rdy, read_rdy, read_data;
    logic cmd_rdy, res_y, res_valid, write_data, write_en, read_en, timeout_err;
    logic [2:0]  write_address, read_address;
    logic [15:0] txn_count;

    or_bus_initiator dut (
        .CLK(CLK), .RST(RST), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid),
        .cmd_rdy(cmd_rdy), .res_y(res_y), .res_valid(res_valid), .res_rdy(res_rdy),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy), .timeout_err(timeout_err),
        .txn_count(txn_count)
    );

    // Timeout instance: Y-FIFO never reports data.
    logic cmd_valid_t = 1'b0;
    logic one = 1'b1, zero = 1'b0;
    logic cmd_rdy_t, res_y_t, res_valid_t, write_data_t, write_en_t, read_en_t, timeout_err_t;
    logic read_data_t;
    logic [2:0]  write_address_t, read_address_t;
    logic [15:0] txn_count_t;

    or_bus_initiator #(.POLL_LIMIT(4)) dut_t (
        .CLK(CLK), .RST(RST), .cmd_a(one), .cmd_b(zero), .cmd_valid(cmd_valid_t),
        .cmd_rdy(cmd_rdy_t), .res_y(res_y_t), .res_valid(res_valid_t), .res_rdy(zero),
        .write_address(write_address_t), .write_data(write_data_t), .write_en(write_en_t),
        .write_rdy(one), .read_address(read_address_t), .read_en(read_en_t),
        .read_data(read_data_t), .read_rdy(one), .timeout_err(timeout_err_t),
        .txn_count(txn_count_t)
    );
    assign read_data_t = (read_address_t != 3'd2);

    // Bus-side model state
    logic m_a = 1'b0, m_b = 1'b0;
    int   rd_cnt [0:7] = '{default: 0};
    int   wr_n = 0, wr4_rd0 = 0, bus_act = 0, proto_err = 0, rd2_t = 0;
    logic [2:0] wr_addr_log [0:255];
    logic       wr_data_log [0:255];
    int   a_base = 0, a_zeros = 0;
    bit   wr_block_b = 1'b0, rand_stall = 1'b0;
    logic stall_r = 1'b1, stall_w = 1'b1;
    logic p_wr_hold = 1'b0, p_rd_hold = 1'b0, p_wd = 1'b0;
    logic [2:0] p_wa = 3'd0, p_ra = 3'd0;

    always @(negedge CLK) begin
        stall_r <= 1'($urandom_range(0, 1));
        stall_w <= 1'($urandom_range(0, 1));
    end

    always_comb begin
        read_rdy  = rand_stall ? stall_r : 1'b1;
        write_rdy = !(wr_block_b && write_address == 3'd5) && (rand_stall ? stall_w : 1'b1);
        case (read_address)
            3'd0:    read_data = ((rd_cnt[0] - a_base) >= a_zeros);
            3'd1:    read_data = 1'b1;
            3'd2:    read_data = 1'b1;
            3'd3:    read_data = m_a | m_b;
            default: read_data = 1'b0;
        endcase
    end

    always @(posedge CLK) begin
        if (RST) begin
            p_wr_hold <= 1'b0;
            p_rd_hold <= 1'b0;
        end else begin
            if (write_en && write_rdy) begin
                wr_addr_log[wr_n] <= write_address;
                wr_data_log[wr_n] <= write_data;
                wr_n <= wr_n + 1;
                if (write_address == REG_A_DATA) begin
                    m_a     <= write_data;
                    wr4_rd0 <= rd_cnt[0];
                end
                if (write_address == REG_B_DATA) m_b <= write_data;
            end
            if (read_en && read_rdy) rd_cnt[read_address] <= rd_cnt[read_address] + 1;
            if (read_en || write_en) bus_act <= bus_act + 1;
            if ((p_wr_hold && !(write_en && write_address == p_wa && write_data == p_wd)) ||
                (p_rd_hold && !(read_en && read_address == p_ra)) || (write_en && read_en))
                proto_err <= proto_err + 1;
            p_wr_hold <= write_en && !write_rdy;
            p_wa      <= write_address;
            p_wd      <= write_data;
            p_rd_hold <= read_en && !read_rdy;
            p_ra      <= read_address;
            if (read_en_t && read_address_t == 3'd2) rd2_t <= rd2_t + 1;
        end
    end

    // Scoreboard and counters
    logic exp_q [$];
    int   exp_txn = 0;
    int   n_tests = 0, n_fail = 0;

    task automatic send_cmd(input logic a, input logic b, output bit ok);
        int k = 0;
        while (cmd_rdy !== 1'b1 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        ok = (cmd_rdy === 1'b1);
        if (ok) begin
            cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
            exp_q.push_back(a | b);
        end
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            lat++;
        end while (res_valid !== 1'b1 && lat < 200);
    endtask

    task automatic accept_res();
        res_rdy = 1'b1;
        @(negedge CLK);
        res_rdy = 1'b0;
        exp_txn++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_tests++;
        if ({cmd_rdy, res_valid, res_y, write_en, read_en, write_address, read_address,
             write_data, timeout_err, txn_count} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_values: got cmd_rdy=%b res_valid=%b res_y=%b wen=%b ren=%b wa=%0d ra=%0d wd=%b to=%b txn=%0d, want all 0",
                     cmd_rdy, res_valid, res_y, write_en, read_en, write_address, read_address,
                     write_data, timeout_err, txn_count);
        end
        RST = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (cmd_rdy !== 1'b1 || cmd_rdy_t !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_cmd_rdy: got %b/%b want 1/1", cmd_rdy, cmd_rdy_t);
        end
    endtask

    task automatic test_single();
        bit ok; int lat; int w0; logic e;
        w0 = wr_n;
        send_cmd(1'b1, 1'b0, ok);
        wait_res(lat);
        n_tests++;
        if (!ok || lat !== 7) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles (sent=%b) want 7", lat, ok);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (res_y !== e) begin
            n_fail++;
            $display("FAIL single_res_y: got %b want %b", res_y, e);
        end
        accept_res();
        n_tests++;
        if (txn_count !== 16'(exp_txn)) begin
            n_fail++;
            $display("FAIL single_txn_count: got %0d want %0d", txn_count, exp_txn);
        end
        n_tests++;
        if (wr_n - w0 !== 2 || wr_addr_log[w0] !== 3'd4 || wr_data_log[w0] !== 1'b1 ||
            wr_addr_log[w0+1] !== 3'd5 || wr_data_log[w0+1] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_writes: got n=%0d a%0d=%b a%0d=%b want n=2 a4=1 a5=0",
                     wr_n - w0, wr_addr_log[w0], wr_data_log[w0], wr_addr_log[w0+1], wr_data_log[w0+1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; int w0; logic e; logic [1:0] ab;
        rand_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            w0 = wr_n;
            send_cmd(ab[1], ab[0], ok);
            wait_res(lat);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || res_valid !== 1'b1 || res_y !== e) begin
                n_fail++;
                $display("FAIL b2b_res_y[%0d]: got %b (valid=%b) want %b", i, res_y, res_valid, e);
            end
            accept_res();
            n_tests++;
            if (wr_n - w0 !== 2 || wr_data_log[w0] !== ab[1] || wr_data_log[w0+1] !== ab[0]) begin
                n_fail++;
                $display("FAIL b2b_writes[%0d]: got n=%0d a=%b b=%b want n=2 a=%b b=%b",
                         i, wr_n - w0, wr_data_log[w0], wr_data_log[w0+1], ab[1], ab[0]);
            end
        end
        rand_stall = 1'b0;
        n_tests++;
        if (txn_count !== 16'(exp_txn)) begin
            n_fail++;
            $display("FAIL b2b_txn_count: got %0d want %0d", txn_count, exp_txn);
        end
    endtask

    task automatic test_poll_a();
        bit ok; int lat; logic e;
        a_base  = rd_cnt[0];
        a_zeros = 10;
        send_cmd(1'b0, 1'b1, ok);
        wait_res(lat);
        n_tests++;
        if (rd_cnt[0] - a_base !== 11) begin
            n_fail++;
            $display("FAIL poll_a_reads: got %0d want 11", rd_cnt[0] - a_base);
        end
        n_tests++;
        if (wr4_rd0 - a_base !== 11) begin
            n_fail++;
            $display("FAIL poll_a_order: got %0d reads before write a4 want 11", wr4_rd0 - a_base);
        end
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || res_valid !== 1'b1 || res_y !== e || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL poll_a_result: got y=%b valid=%b to=%b want y=%b valid=1 to=0",
                     res_y, res_valid, timeout_err, e);
        end
        accept_res();
        a_zeros = 0;
    endtask

    task automatic test_backpressure();
        bit ok; int lat; int act0; logic e;
        send_cmd(1'b1, 1'b1, ok);
        wait_res(lat);
        e = exp_q.pop_front();
        act0 = bus_act;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_tests++;
            if (!ok || res_valid !== 1'b1 || res_y !== e) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b y=%b want valid=1 y=%b", c, res_valid, res_y, e);
            end
        end
        n_tests++;
        if (bus_act !== act0 || cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_quiet: got %0d bus cycles cmd_rdy=%b want 0 and 0", bus_act - act0, cmd_rdy);
        end
        accept_res();
        n_tests++;
        if (txn_count !== 16'(exp_txn) || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: got txn=%0d valid=%b want txn=%0d valid=0", txn_count, res_valid, exp_txn);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; int k; logic e;
        wr_block_b = 1'b1;
        send_cmd(1'b1, 1'b0, ok);
        k = 0;
        do begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            k++;
        end while (!(write_en === 1'b1 && write_address === 3'd5) && k < 50);
        n_tests++;
        if (!ok || k >= 50) begin
            n_fail++;
            $display("FAIL rstmid_reach_wr_b: got wen=%b wa=%0d after %0d cycles want wen=1 wa=5", write_en, write_address, k);
        end
        RST = 1'b1;
        #1;
        void'(exp_q.pop_back());
        n_tests++;
        if (write_en !== 1'b0 || read_en !== 1'b0 || cmd_rdy !== 1'b0 || txn_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_immediate: got wen=%b ren=%b cmd_rdy=%b txn=%0d want 0 0 0 0",
                     write_en, read_en, cmd_rdy, txn_count);
        end
        @(negedge CLK);
        RST = 1'b0;
        wr_block_b = 1'b0;
        exp_txn = 0;
        @(negedge CLK);
        n_tests++;
        if (cmd_rdy !== 1'b1 || write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got cmd_rdy=%b wen=%b want 1 0", cmd_rdy, write_en);
        end
        send_cmd(1'b0, 1'b1, ok);
        wait_res(lat);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || lat !== 7 || res_y !== e) begin
            n_fail++;
            $display("FAIL rstmid_new_cmd: got lat=%0d y=%b want lat=7 y=%b", lat, res_y, e);
        end
        accept_res();
        n_tests++;
        if (txn_count !== 16'(exp_txn)) begin
            n_fail++;
            $display("FAIL rstmid_txn_count: got %0d want %0d", txn_count, exp_txn);
        end
    endtask

    task automatic test_timeout();
        int r0; int k; int r_at;
        r0 = rd2_t;
        cmd_valid_t = 1'b1;
        k = 0;
        do begin
            @(negedge CLK);
            cmd_valid_t = 1'b0;
            k++;
        end while (timeout_err_t !== 1'b1 && k < 100);
        n_tests++;
        if (k >= 100) begin
            n_fail++;
            $display("FAIL timeout_flag: got timeout_err=%b after %0d cycles want 1", timeout_err_t, k);
        end
        n_tests++;
        if (rd2_t - r0 !== 4) begin
            n_fail++;
            $display("FAIL timeout_polls: got %0d polls want 4", rd2_t - r0);
        end
        n_tests++;
        if (cmd_rdy_t !== 1'b1 || txn_count_t !== 16'd0 || res_valid_t !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: got cmd_rdy=%b txn=%0d valid=%b want 1 0 0", cmd_rdy_t, txn_count_t, res_valid_t);
        end
        r_at = rd2_t;
        repeat (4) @(negedge CLK);
        n_tests++;
        if (timeout_err_t !== 1'b1 || rd2_t !== r_at || read_en_t !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got to=%b extra_polls=%0d ren=%b want 1 0 0", timeout_err_t, rd2_t - r_at, read_en_t);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_poll_a();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        n_tests++;
        if (proto_err !== 0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_protocol: got %0d violations timeout_err=%b want 0 0", proto_err, timeout_err);
        end
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/or_bus_initiator.md
OR_BUS_INITIATOR -- requirements
Module: or_bus_initiator

Interface
REQ-001 Parameter: POLL_LIMIT, default 255, meaning maximum status polls per phase before timeout.
REQ-002 Port: CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_a  input  1  operand A of the requested operation.
REQ-005 Port: cmd_b  input  1  operand B of the requested operation.
REQ-006 Port: cmd_valid  input  1  command present.
REQ-007 Port: cmd_rdy  output  1  initiator accepts a command.
REQ-008 Port: res_y  output  1  result bit returned by the DUT.
REQ-009 Port: res_valid  output  1  result present.
REQ-010 Port: res_rdy  input  1  consumer accepts the result.
REQ-011 Port: write_address  output  3  DUT register write address.
REQ-012 Port: write_data  output  1  DUT register write data.
REQ-013 Port: write_en  output  1  write request.
REQ-014 Port: write_rdy  input  1  DUT can accept a write.
REQ-015 Port: read_address  output  3  DUT register read address.
REQ-016 Port: read_en  output  1  read request.
REQ-017 Port: read_data  input  1  DUT read data, valid in the handshake cycle.
REQ-018 Port: read_rdy  input  1  DUT can accept a read.
REQ-019 Port: timeout_err  output  1  sticky error flag, set on poll-limit expiry.
REQ-020 Port: txn_count  output  16  count of completed results.

Function
REQ-021 DUT register map: read 0 = A-FIFO not-full, read 1 = B-FIFO not-full, read 2 = Y-FIFO not-empty, read 3 = Y data, write 4 = A data, write 5 = B data.
REQ-022 Write completes in the cycle where write_en and write_rdy are both 1; read completes, and read_data is sampled, in the cycle where read_en and read_rdy are both 1.
REQ-023 write_en/read_en, once asserted, stay asserted with stable address/data until completion; never both in one cycle.
REQ-024 States: IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RESP.
REQ-025 IDLE: cmd_rdy=1; on cmd_valid capture cmd_a/cmd_b, go to POLL_A.
REQ-026 POLL_A: read addr 0; completed read returning 1 -> WR_A, returning 0 -> re-poll next cycle.
REQ-027 WR_A: write addr 4, data = captured A; completion -> POLL_B.
REQ-028 POLL_B/WR_B: as REQ-026/027 with addr 1 and addr 5; WR_B completion -> POLL_Y.
REQ-029 POLL_Y: read addr 2; returning 1 -> RD_Y, returning 0 -> re-poll.
REQ-030 RD_Y: read addr 3; completion captures read_data into res_y and goes to RESP.
REQ-031 RESP: res_valid=1; when res_rdy=1, increment txn_count and go to IDLE; res_y stable while res_valid=1.
REQ-032 Per-phase 8-bit poll counter, cleared on entering each POLL state and counting completed polls returning 0; reaching POLL_LIMIT sets timeout_err and returns to IDLE, discarding the command.
REQ-033 txn_count wraps from 0xFFFF to 0x0000.
REQ-034 timeout_err clears only on reset.
REQ-035 Minimum transaction with all ready and status 1: 7 bus cycles from command acceptance to res_valid.

Reset
REQ-036 RST asserted forces IDLE immediately, including mid-transaction; a pending command is dropped.
REQ-037 Reset values: cmd_rdy=0 during reset, 1 after; res_valid=0, res_y=0, write_en=0, read_en=0, addresses=0, write_data=0, timeout_err=0, txn_count=0.

Structure
REQ-038 Shared package holds register address constants (0-5), state enumeration, and POLL_LIMIT default.
REQ-039 Single flat module; no sub-module.

Verification
REQ-040 A=1,B=0, DUT model always ready -> writes addr4=1, addr5=0, res_y=1, txn_count=1.
REQ-041 All four operand combinations back-to-back -> res_y = 0,1,1,1 in order, txn_count=4.
REQ-042 A-FIFO status 0 for 10 polls, then 1 -> exactly 11 reads at addr 0, then write addr 4.
REQ-043 Y-FIFO status stuck 0, POLL_LIMIT=4 -> 4 polls, timeout_err=1, return to IDLE, txn_count unchanged.
REQ-044 RST pulsed during WR_B, with write_rdy held 0 -> write_en=0 immediately, state IDLE, new command completes normally.
REQ-045 res_rdy held 0 for 5 cycles -> res_valid and res_y stable, no new bus activity.
